// File: rtl/memory_stage_if.sv
// Execute-to-memory handshake, data-memory bus and writeback result bundle.
interface memory_stage_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] ALU_RESULT;
  logic [31:0] RS_2;
  logic        MEM_RDEN;
  logic        MEM_WE;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [4:0]  RD_ADDR;
  logic        REG_WE;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic        DMEM_ACK;
  logic [31:0] DMEM_RDATA;
  logic        WB_VALID;
  logic [31:0] WB_DATA;
  logic [4:0]  WB_RD;
  logic        WB_REG_WE;
  logic        ERR_ALIGN;
  logic        ERR_TIMEOUT;

  // The memory stage itself.
  modport slave (
    input  IN_VALID, ALU_RESULT, RS_2, MEM_RDEN, MEM_WE, MEM_SIZE, MEM_SIGN,
           RD_ADDR, REG_WE, DMEM_ACK, DMEM_RDATA,
    output IN_READY, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE,
           WB_VALID, WB_DATA, WB_RD, WB_REG_WE, ERR_ALIGN, ERR_TIMEOUT
  );

  // The surrounding pipeline / memory model.
  modport master (
    output IN_VALID, ALU_RESULT, RS_2, MEM_RDEN, MEM_WE, MEM_SIZE, MEM_SIGN,
           RD_ADDR, REG_WE, DMEM_ACK, DMEM_RDATA,
    input  IN_READY, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE,
           WB_VALID, WB_DATA, WB_RD, WB_REG_WE, ERR_ALIGN, ERR_TIMEOUT
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: ALU pass-through, aligned load/store via a
// request/ack data-memory bus with timeout, one writeback pulse per op.
module memory_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           MEM_CLK,
  input logic           MEM_RST,
  memory_stage_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          accept, is_mem, misalign, ack_fire, to_fire;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   lane, load_data;
  logic [1:0]    cap_off;
  logic [1:0]    cap_size;
  logic          cap_uns;
  logic          cap_load;
  logic          cap_reg_we;
  logic [4:0]    cap_rd;

  assign bus.IN_READY = (state == IDLE);

  // Acceptance, alignment check and next-state selection.
  always_comb begin
    accept    = bus.IN_VALID && (state == IDLE);
    is_mem    = bus.MEM_RDEN || bus.MEM_WE;
    misalign  = ((bus.MEM_SIZE == 2'b01) && bus.ALU_RESULT[0])
             || ((bus.MEM_SIZE == 2'b10) && (bus.ALU_RESULT[1:0] != 2'b00))
             || (bus.MEM_SIZE == 2'b11)
             || (bus.MEM_RDEN && bus.MEM_WE);
    ack_fire  = (state == REQ) && bus.DMEM_ACK;
    to_fire   = (state == REQ) && !bus.DMEM_ACK && (wait_cnt == CW'(TIMEOUT - 1));
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_mem && !misalign) state_nxt = REQ;
      REQ:  if (ack_fire || to_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Store lane steering: replicate data across lanes, enable only the target bytes.
  always_comb begin
    st_be    = '0;
    st_wdata = bus.RS_2;
    if (bus.MEM_WE) begin
      case (bus.MEM_SIZE)
        2'b00: begin
          st_be    = 4'b0001 << bus.ALU_RESULT[1:0];
          st_wdata = {4{bus.RS_2[7:0]}};
        end
        2'b01: begin
          st_be    = bus.ALU_RESULT[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{bus.RS_2[15:0]}};
        end
        default: st_be = 4'b1111;
      endcase
    end
  end

  // Load extraction: shift the addressed lane down, then sign/zero extend.
  always_comb begin
    lane      = bus.DMEM_RDATA >> {cap_off, 3'b000};
    load_data = lane;
    case (cap_size)
      2'b00:   load_data = cap_uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_data = cap_uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // State register.
  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  // Registered bus outputs, writeback pulse, captured op fields and wait counter.
  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      bus.DMEM_REQ    <= 1'b0;
      bus.DMEM_WE     <= 1'b0;
      bus.DMEM_BE     <= '0;
      bus.DMEM_ADDR   <= '0;
      bus.DMEM_WDATA  <= '0;
      bus.WB_VALID    <= 1'b0;
      bus.WB_DATA     <= '0;
      bus.WB_RD       <= '0;
      bus.WB_REG_WE   <= 1'b0;
      bus.ERR_ALIGN   <= 1'b0;
      bus.ERR_TIMEOUT <= 1'b0;
      wait_cnt        <= '0;
      cap_off         <= '0;
      cap_size        <= '0;
      cap_uns         <= 1'b0;
      cap_load        <= 1'b0;
      cap_reg_we      <= 1'b0;
      cap_rd          <= '0;
    end else begin
      bus.WB_VALID    <= 1'b0;
      bus.ERR_ALIGN   <= 1'b0;
      bus.ERR_TIMEOUT <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          bus.WB_VALID  <= 1'b1;
          bus.WB_DATA   <= bus.ALU_RESULT;
          bus.WB_RD     <= bus.RD_ADDR;
          bus.WB_REG_WE <= bus.REG_WE;
        end else if (misalign) begin
          bus.WB_VALID  <= 1'b1;
          bus.WB_DATA   <= '0;
          bus.WB_RD     <= bus.RD_ADDR;
          bus.WB_REG_WE <= 1'b0;
          bus.ERR_ALIGN <= 1'b1;
        end else begin
          bus.DMEM_REQ   <= 1'b1;
          bus.DMEM_WE    <= bus.MEM_WE;
          bus.DMEM_ADDR  <= {bus.ALU_RESULT[31:2], 2'b00};
          bus.DMEM_BE    <= st_be;
          bus.DMEM_WDATA <= st_wdata;
          wait_cnt       <= '0;
          cap_off        <= bus.ALU_RESULT[1:0];
          cap_size       <= bus.MEM_SIZE;
          cap_uns        <= bus.MEM_SIGN;
          cap_load       <= bus.MEM_RDEN;
          cap_reg_we     <= bus.REG_WE;
          cap_rd         <= bus.RD_ADDR;
        end
      end else if (ack_fire) begin
        bus.DMEM_REQ  <= 1'b0;
        bus.WB_VALID  <= 1'b1;
        bus.WB_DATA   <= cap_load ? load_data : '0;
        bus.WB_RD     <= cap_rd;
        bus.WB_REG_WE <= cap_load && cap_reg_we;
      end else if (to_fire) begin
        bus.DMEM_REQ    <= 1'b0;
        bus.WB_VALID    <= 1'b1;
        bus.WB_DATA     <= '0;
        bus.WB_RD       <= cap_rd;
        bus.WB_REG_WE   <= 1'b0;
        bus.ERR_TIMEOUT <= 1'b1;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a writeback scoreboard.
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   wb_seen = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        e_al;
    logic        e_to;
    logic        chk_data;
  } wb_t;

  wb_t sb[$];

  memory_stage_if bus ();

  memory_stage #(.TIMEOUT(4)) dut (
    .MEM_CLK (clk),
    .MEM_RST (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic we,
                      input logic al, input logic to, input logic cd);
    wb_t e;
    e.data = d; e.rd = rd; e.reg_we = we; e.e_al = al; e.e_to = to; e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] rs2, input logic rden,
                          input logic we, input logic [1:0] size, input logic uns,
                          input logic [4:0] rd, input logic reg_we);
    bus.IN_VALID = 1'b1; bus.ALU_RESULT = alu; bus.RS_2 = rs2;
    bus.MEM_RDEN = rden; bus.MEM_WE = we; bus.MEM_SIZE = size; bus.MEM_SIGN = uns;
    bus.RD_ADDR = rd; bus.REG_WE = reg_we;
  endtask

  // Scoreboard monitor: every WB_VALID pulse must match the oldest expectation.
  always @(negedge clk) begin
    wb_t e;
    if (mon_en) begin
      if (bus.WB_VALID === 1'b1) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", {31'b0, bus.WB_VALID}, 32'd0);
        end else begin
          e = sb.pop_front();
          wb_seen++;
          chk("wb_rd", {27'b0, bus.WB_RD}, {27'b0, e.rd});
          chk("wb_reg_we", {31'b0, bus.WB_REG_WE}, {31'b0, e.reg_we});
          chk("wb_err_align", {31'b0, bus.ERR_ALIGN}, {31'b0, e.e_al});
          chk("wb_err_timeout", {31'b0, bus.ERR_TIMEOUT}, {31'b0, e.e_to});
          if (e.chk_data) chk("wb_data", bus.WB_DATA, e.data);
        end
      end else begin
        chk("err_align_idle", {31'b0, bus.ERR_ALIGN}, 32'd0);
        chk("err_timeout_idle", {31'b0, bus.ERR_TIMEOUT}, 32'd0);
      end
    end
  end

  initial begin
    int req_cycles;
    rst = 1'b1;
    bus.IN_VALID = 1'b0; bus.ALU_RESULT = '0; bus.RS_2 = '0; bus.MEM_RDEN = 1'b0;
    bus.MEM_WE = 1'b0; bus.MEM_SIZE = 2'b00; bus.MEM_SIGN = 1'b0; bus.RD_ADDR = '0;
    bus.REG_WE = 1'b0; bus.DMEM_ACK = 1'b0; bus.DMEM_RDATA = '0;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_dmem_req", {31'b0, bus.DMEM_REQ}, 32'd0);
    chk("rst_dmem_we", {31'b0, bus.DMEM_WE}, 32'd0);
    chk("rst_dmem_be", {28'b0, bus.DMEM_BE}, 32'd0);
    chk("rst_dmem_addr", bus.DMEM_ADDR, 32'd0);
    chk("rst_dmem_wdata", bus.DMEM_WDATA, 32'd0);
    chk("rst_wb_valid", {31'b0, bus.WB_VALID}, 32'd0);
    chk("rst_wb_data", bus.WB_DATA, 32'd0);
    chk("rst_wb_rd", {27'b0, bus.WB_RD}, 32'd0);
    chk("rst_wb_reg_we", {31'b0, bus.WB_REG_WE}, 32'd0);
    chk("rst_err", {30'b0, bus.ERR_ALIGN, bus.ERR_TIMEOUT}, 32'd0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    @(negedge clk);
    chk("ready_after_reset", {31'b0, bus.IN_READY}, 32'd1);

    // Pass-through: three back-to-back ALU ops
    step();
    for (int i = 1; i <= 3; i++) begin
      drive_op(i, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 5'(i + 4), 1'b1);
      push(i, 5'(i + 4), 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("pt_in_ready", {31'b0, bus.IN_READY}, 32'd1);
      step();
    end
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    chk("pt_in_ready_end", {31'b0, bus.IN_READY}, 32'd1);
    step();

    // ACK while idle must be ignored
    bus.DMEM_ACK = 1'b1;
    step();
    bus.DMEM_ACK = 1'b0;
    step();

    // Signed byte load at 0x1003, ACK in the second REQ cycle
    drive_op(32'h1003, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd7, 1'b1);
    push(32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    chk("ld_req", {31'b0, bus.DMEM_REQ}, 32'd1);
    chk("ld_addr", bus.DMEM_ADDR, 32'h1000);
    chk("ld_be", {28'b0, bus.DMEM_BE}, 32'd0);
    chk("ld_we", {31'b0, bus.DMEM_WE}, 32'd0);
    chk("ld_not_ready", {31'b0, bus.IN_READY}, 32'd0);
    step();
    bus.DMEM_ACK = 1'b1;
    bus.DMEM_RDATA = 32'h80AA_BBCC;
    @(negedge clk);
    chk("ld_req_hold", {31'b0, bus.DMEM_REQ}, 32'd1);
    chk("ld_addr_hold", bus.DMEM_ADDR, 32'h1000);
    step();
    bus.DMEM_ACK = 1'b0;
    @(negedge clk);
    chk("ld_req_drop", {31'b0, bus.DMEM_REQ}, 32'd0);
    chk("ld_ready_back", {31'b0, bus.IN_READY}, 32'd1);
    step();

    // Half store at 0x2002, ACK in the first REQ cycle
    drive_op(32'h2002, 32'h1234_ABCD, 1'b0, 1'b1, 2'b01, 1'b0, 5'd3, 1'b1);
    push(32'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bus.IN_VALID = 1'b0;
    bus.DMEM_ACK = 1'b1;
    @(negedge clk);
    chk("sh_req", {31'b0, bus.DMEM_REQ}, 32'd1);
    chk("sh_we", {31'b0, bus.DMEM_WE}, 32'd1);
    chk("sh_addr", bus.DMEM_ADDR, 32'h2000);
    chk("sh_be", {28'b0, bus.DMEM_BE}, 32'b1100);
    chk("sh_wdata", bus.DMEM_WDATA, 32'hABCD_ABCD);
    step();
    bus.DMEM_ACK = 1'b0;
    step();

    // Byte store at 0x3001
    drive_op(32'h3001, 32'h0000_00A5, 1'b0, 1'b1, 2'b00, 1'b0, 5'd4, 1'b1);
    push(32'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    chk("sb_be", {28'b0, bus.DMEM_BE}, 32'b0010);
    chk("sb_wdata", bus.DMEM_WDATA, 32'hA5A5_A5A5);
    bus.DMEM_ACK = 1'b1;
    step();
    bus.DMEM_ACK = 1'b0;
    step();

    // Unsigned half load at 0x4002
    drive_op(32'h4002, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd9, 1'b1);
    push(32'h0000_8001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    bus.IN_VALID = 1'b0;
    bus.DMEM_ACK = 1'b1;
    bus.DMEM_RDATA = 32'h8001_7FFF;
    step();
    bus.DMEM_ACK = 1'b0;
    step();

    // Misaligned word load at 0x0006
    drive_op(32'h0000_0006, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd11, 1'b1);
    push(32'd0, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    chk("mis_no_req", {31'b0, bus.DMEM_REQ}, 32'd0);
    chk("mis_ready", {31'b0, bus.IN_READY}, 32'd1);
    step();
    @(negedge clk);
    chk("mis_no_req2", {31'b0, bus.DMEM_REQ}, 32'd0);
    step();

    // Timeout: load never acknowledged, TIMEOUT = 4
    drive_op(32'h0000_0010, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd12, 1'b1);
    push(32'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    bus.IN_VALID = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.DMEM_REQ !== 1'b1) break;
      req_cycles++;
    end
    chk("to_req_cycles", req_cycles, 32'd4);
    chk("to_ready_back", {31'b0, bus.IN_READY}, 32'd1);
    step();
    step();

    // Reset in the second REQ cycle, with ACK present
    drive_op(32'h0000_0020, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd13, 1'b1);
    step();
    bus.IN_VALID = 1'b0;
    step();
    rst = 1'b1;
    bus.DMEM_ACK = 1'b1;
    step();
    rst = 1'b0;
    bus.DMEM_ACK = 1'b0;
    @(negedge clk);
    chk("rr_req", {31'b0, bus.DMEM_REQ}, 32'd0);
    chk("rr_wb_valid", {31'b0, bus.WB_VALID}, 32'd0);
    chk("rr_ready", {31'b0, bus.IN_READY}, 32'd1);
    step();
    @(negedge clk);
    chk("rr_wb_valid2", {31'b0, bus.WB_VALID}, 32'd0);
    step();

    // Pass-through still works afterwards
    drive_op(32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd31, 1'b1);
    push(32'hDEAD_BEEF, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    bus.IN_VALID = 1'b0;

    // Drain: every expectation must have been matched
    repeat (4) step();
    chk("sb_drain", sb.size(), 32'd0);
    chk("wb_count", wb_seen, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
